// File: rtl/ysyx_22050854_mdu_pkg.sv
// Shared opcode, state and signedness definitions for the multiply/divide unit.
package ysyx_22050854_mdu_pkg;

    localparam int MDU_XLEN = 64;

    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    // rs1 is treated as signed for every op except MULHU, DIVU, REMU
    function automatic logic src1_signed(input logic [2:0] f3);
        return (f3 == MDU_MUL) || (f3 == MDU_MULH) || (f3 == MDU_MULHSU) ||
               (f3 == MDU_DIV) || (f3 == MDU_REM);
    endfunction

    // rs2 is signed only for MUL, MULH, DIV, REM
    function automatic logic src2_signed(input logic [2:0] f3);
        return (f3 == MDU_MUL) || (f3 == MDU_MULH) ||
               (f3 == MDU_DIV) || (f3 == MDU_REM);
    endfunction

endpackage

// File: rtl/ysyx_22050854_div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when it does not go negative.
module ysyx_22050854_div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN:0]   part_rem,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] next_rem,
    output logic            q_bit
);

    logic [XLEN:0] diff;

    // partial remainder is always below 2*divisor, so the sign bit of the
    // (XLEN+1)-bit difference decides the quotient bit
    always_comb begin
        diff     = part_rem - {1'b0, divisor};
        q_bit    = ~diff[XLEN];
        next_rem = q_bit ? diff[XLEN-1:0] : part_rem[XLEN-1:0];
    end

endmodule

// File: rtl/ysyx_22050854_mdu.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, sign fix in the last iteration.
//
// state | meaning
// IDLE  | waiting for an op, in_ready=1
// BUSY  | iterating, one product/quotient bit per clock
// DONE  | result held with out_valid=1 until out_ready
module ysyx_22050854_mdu
    import ysyx_22050854_mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      mdu_op,
    input  logic [XLEN-1:0] alu_src1,
    input  logic [XLEN-1:0] alu_src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int W  = XLEN / 2;
    localparam int CW = $clog2(XLEN);

    function automatic logic [XLEN-1:0] sext_w(input logic [W-1:0] v);
        return {{(XLEN-W){v[W-1]}}, v};
    endfunction

    mdu_state_e        state, state_nxt;
    logic              word_q, neg_q_q, neg_r_q;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   result_q;

    logic              accept, word_in, a_sgn, b_sgn, a_neg, b_neg;
    logic              div_zero, div_ovf, special;
    logic [2:0]        f3_in;
    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, spec_raw, special_res, opnd_init;
    logic [2*XLEN-1:0] acc_init;

    // decode the incoming op; MULHW-style encodings fold onto MULW
    always_comb begin
        word_in = mdu_op[3];
        f3_in   = mdu_op[2:0];
        if (word_in && (f3_in == MDU_MULH || f3_in == MDU_MULHSU || f3_in == MDU_MULHU))
            f3_in = MDU_MUL;
        a_sgn = src1_signed(f3_in);
        b_sgn = src2_signed(f3_in);
        a_ext = word_in ? (a_sgn ? sext_w(alu_src1[W-1:0]) : {{(XLEN-W){1'b0}}, alu_src1[W-1:0]})
                        : alu_src1;
        b_ext = word_in ? (b_sgn ? sext_w(alu_src2[W-1:0]) : {{(XLEN-W){1'b0}}, alu_src2[W-1:0]})
                        : alu_src2;
        a_neg = a_sgn & a_ext[XLEN-1];
        b_neg = b_sgn & b_ext[XLEN-1];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;

        div_zero = f3_in[2] && (b_ext == '0);
        div_ovf  = f3_in[2] && a_sgn && (b_ext == '1) &&
                   (a_ext == (word_in ? sext_w({1'b1, {(W-1){1'b0}}}) : {1'b1, {(XLEN-1){1'b0}}}));
        special  = div_zero | div_ovf;
        if (!f3_in[1]) spec_raw = div_zero ? '1 : a_ext;
        else           spec_raw = div_zero ? a_ext : '0;
        special_res = word_in ? sext_w(spec_raw[W-1:0]) : spec_raw;

        // word divides park the dividend in the upper half so W shifts suffice
        if (f3_in[2]) begin
            acc_init  = {{XLEN{1'b0}}, (word_in ? {a_mag[W-1:0], {W{1'b0}}} : a_mag)};
            opnd_init = b_mag;
        end else begin
            acc_init  = {{XLEN{1'b0}}, b_mag};
            opnd_init = a_mag;
        end
        accept = in_valid && (state == IDLE) && !flush;
    end

    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   step_rem;
    logic              step_q;
    logic [2*XLEN-1:0] acc_nxt, prod_fix;
    logic [XLEN-1:0]   mul_lo, quo_fix, rem_fix, raw_res, final_res;

    ysyx_22050854_div_step #(.XLEN(XLEN)) u_div_step (
        .part_rem (acc_q[2*XLEN-1:XLEN-1]),
        .divisor  (opnd_q),
        .next_rem (step_rem),
        .q_bit    (step_q)
    );

    // one iteration, plus the signed result it would produce if it is the last
    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        if (f3_q[2]) acc_nxt = {step_rem, acc_q[XLEN-2:0], step_q};
        else         acc_nxt = {mul_sum, acc_q[XLEN-1:1]};

        prod_fix = neg_q_q ? -acc_nxt : acc_nxt;
        quo_fix  = neg_q_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rem_fix  = neg_r_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
        // word products finish shifted left by W, so the low word sits above bit W
        mul_lo   = word_q ? (prod_fix[XLEN-1:0] >> W) : prod_fix[XLEN-1:0];
        case (f3_q)
            MDU_MUL:                          raw_res = mul_lo;
            MDU_MULH, MDU_MULHSU, MDU_MULHU:  raw_res = prod_fix[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:                raw_res = quo_fix;
            default:                          raw_res = rem_fix;
        endcase
        final_res = word_q ? sext_w(raw_res[W-1:0]) : raw_res;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state and handshake outputs; flush overrides everything
    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        case (state)
            IDLE:    if (accept) state_nxt = special ? DONE : BUSY;
            BUSY:    if (cnt_q == '0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // operand latch at accept, iteration down-counter, result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q   <= 1'b0;
            f3_q     <= MDU_MUL;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            word_q   <= word_in;
            f3_q     <= f3_in;
            neg_q_q  <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            opnd_q   <= opnd_init;
            acc_q    <= acc_init;
            cnt_q    <= word_in ? CW'(W - 1) : CW'(XLEN - 1);
            if (special) result_q <= special_res;
        end else if (state == BUSY && !flush) begin
            acc_q <= acc_nxt;
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            else             result_q <= final_res;
        end
    end

    assign result = result_q;

endmodule
